// File: rtl/cpu_ram_deswiz_reader.sv
// Block-read de-swizzler: fans a linear CPU read across NLANES striped lane
// RAMs and reassembles the returned words into one in-order output stream.
//
// state | meaning
// IDLE  | ready for a request; latches lane pointers, cursor and length
// ISSUE | one lane read per cycle while credit allows
// DRAIN | all reads issued; wait for returns and for the FIFO to empty
module cpu_ram_deswiz_reader #(
  parameter int NLANES     = 4,
  parameter int SWIZ_BITS  = 2,
  parameter int TOTAL_BITS = 16,
  parameter int WIDTH      = 32,
  parameter int LEN_BITS   = 8,
  parameter int RAM_LAT    = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    i_req_valid,
  output logic                                    o_req_ready,
  input  logic [TOTAL_BITS-1:0]                   i_req_addr,
  input  logic [LEN_BITS-1:0]                     i_req_len,
  output logic [NLANES-1:0]                       o_ram_rd,
  output logic [NLANES*(TOTAL_BITS-SWIZ_BITS)-1:0] o_ram_addr,
  input  logic [NLANES*WIDTH-1:0]                 i_ram_data,
  output logic [WIDTH-1:0]                        o_data,
  output logic                                    o_valid,
  input  logic                                    i_ready,
  output logic                                    o_last
);
  localparam int LOC_BITS = TOTAL_BITS - SWIZ_BITS;
  localparam int PTR_BITS = $clog2(FIFO_DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;
  localparam int SUM_BITS = CNT_BITS + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                 state_q;
  logic                   req_ready_q;
  logic [LOC_BITS-1:0]    ptr_q  [NLANES];
  logic [LOC_BITS-1:0]    addr_q [NLANES];
  logic [SWIZ_BITS-1:0]   cursor_q;
  logic [LEN_BITS-1:0]    remaining_q;

  logic                   sr_vld_q  [RAM_LAT];
  logic [SWIZ_BITS-1:0]   sr_lane_q [RAM_LAT];
  logic                   sr_last_q [RAM_LAT];

  logic [WIDTH-1:0]       fifo_data_q [FIFO_DEPTH];
  logic                   fifo_last_q [FIFO_DEPTH];
  logic [PTR_BITS-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_BITS-1:0]    count_q, count_d;
  logic [CNT_BITS-1:0]    in_flight_q, in_flight_d;

  logic [WIDTH-1:0]       ram_data_w [NLANES];
  logic [SWIZ_BITS-1:0]   a_lo;
  logic [LOC_BITS-1:0]    a_hi;
  logic                   accept, credit, issue, push, pop;

  assign a_lo   = i_req_addr[SWIZ_BITS-1:0];
  assign a_hi   = i_req_addr[TOTAL_BITS-1:SWIZ_BITS];
  assign accept = i_req_valid & req_ready_q;
  // Reads still in the pipe plus words waiting in the FIFO must never exceed its depth.
  assign credit = ({1'b0, in_flight_q} + {1'b0, count_q}) < SUM_BITS'(FIFO_DEPTH);
  assign issue  = (state_q == ISSUE) && credit;
  assign push   = sr_vld_q[RAM_LAT-1];
  assign pop    = o_valid & i_ready;

  assign in_flight_d = in_flight_q + CNT_BITS'(issue) - CNT_BITS'(push);
  assign count_d     = count_q + CNT_BITS'(push) - CNT_BITS'(pop);

  assign o_req_ready = req_ready_q;
  assign o_valid     = (count_q != '0);
  assign o_data      = o_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign o_last      = o_valid ? fifo_last_q[rd_ptr_q] : 1'b0;

  // One-hot read strobe for the lane under the cursor.
  always_comb begin
    o_ram_rd = '0;
    if (issue) o_ram_rd[cursor_q] = 1'b1;
  end

  for (genvar l = 0; l < NLANES; l++) begin : g_lane
    assign ram_data_w[l] = i_ram_data[l*WIDTH +: WIDTH];
    // Live pointer while reading, otherwise the last address presented.
    assign o_ram_addr[l*LOC_BITS +: LOC_BITS] = o_ram_rd[l] ? ptr_q[l] : addr_q[l];
  end

  // Request sequencing, lane pointers and cursor.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      cursor_q    <= '0;
      remaining_q <= '0;
      for (int l = 0; l < NLANES; l++) begin
        ptr_q[l]  <= '0;
        addr_q[l] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (accept) begin
            // Lanes below the start lane begin one row further up.
            for (int l = 0; l < NLANES; l++)
              ptr_q[l] <= a_hi + LOC_BITS'(a_lo > SWIZ_BITS'(l));
            cursor_q    <= a_lo;
            remaining_q <= i_req_len;
            if (i_req_len != '0) begin
              state_q     <= ISSUE;
              req_ready_q <= 1'b0;
            end
          end
        end
        ISSUE: begin
          if (issue) begin
            ptr_q[cursor_q]  <= ptr_q[cursor_q] + LOC_BITS'(1);
            addr_q[cursor_q] <= ptr_q[cursor_q];
            cursor_q         <= cursor_q + SWIZ_BITS'(1);
            remaining_q      <= remaining_q - LEN_BITS'(1);
            if (remaining_q == LEN_BITS'(1)) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (in_flight_d == '0 && count_d == '0) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Return shift register tracking each read until its data lands, plus FIFO bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < RAM_LAT; s++) begin
        sr_vld_q[s]  <= 1'b0;
        sr_lane_q[s] <= '0;
        sr_last_q[s] <= 1'b0;
      end
      in_flight_q <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      sr_vld_q[0]  <= issue;
      sr_lane_q[0] <= cursor_q;
      sr_last_q[0] <= (remaining_q == LEN_BITS'(1));
      for (int s = 1; s < RAM_LAT; s++) begin
        sr_vld_q[s]  <= sr_vld_q[s-1];
        sr_lane_q[s] <= sr_lane_q[s-1];
        sr_last_q[s] <= sr_last_q[s-1];
      end
      in_flight_q <= in_flight_d;
      count_q     <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_BITS'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_BITS'(1);
    end
  end

  // FIFO storage; contents are don't-care while empty since outputs are gated.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= ram_data_w[sr_lane_q[RAM_LAT-1]];
      fifo_last_q[wr_ptr_q] <= sr_last_q[RAM_LAT-1];
    end
  end
endmodule

// File: tb/tb_cpu_ram_deswiz_reader.sv
// Bench for cpu_ram_deswiz_reader: lane RAM model, address-order scoreboard,
// table of request vectors, random requests and hand-written corner sequences.
module tb_cpu_ram_deswiz_reader;
  localparam int NLANES = 4, SWIZ_BITS = 2, TOTAL_BITS = 16, WIDTH = 32;
  localparam int LEN_BITS = 8, RAM_LAT = 2, FIFO_DEPTH = 8;
  localparam int LB = TOTAL_BITS - SWIZ_BITS;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    i_req_valid;
  logic                    o_req_ready;
  logic [TOTAL_BITS-1:0]   i_req_addr;
  logic [LEN_BITS-1:0]     i_req_len;
  logic [NLANES-1:0]       o_ram_rd;
  logic [NLANES*LB-1:0]    o_ram_addr;
  logic [NLANES*WIDTH-1:0] i_ram_data;
  logic [WIDTH-1:0]        o_data;
  logic                    o_valid;
  logic                    i_ready;
  logic                    o_last;

  cpu_ram_deswiz_reader #(
    .NLANES(NLANES), .SWIZ_BITS(SWIZ_BITS), .TOTAL_BITS(TOTAL_BITS), .WIDTH(WIDTH),
    .LEN_BITS(LEN_BITS), .RAM_LAT(RAM_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_addr(i_req_addr), .i_req_len(i_req_len), .o_ram_rd(o_ram_rd),
    .o_ram_addr(o_ram_addr), .i_ram_data(i_ram_data), .o_data(o_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_last(o_last)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  int ready_mode = 0;
  bit mon_en = 1'b0;

  logic [TOTAL_BITS-1:0] exp_q[$];
  bit                    exp_last_q[$];
  logic [TOTAL_BITS-1:0] rd_exp_q[$];
  int issued_tot = 0, popped_tot = 0;
  int blk_words = 0, blk_issued = 0, first_vld_cyc = -1, acc_cyc = 0;
  logic [TOTAL_BITS-1:0] last_pop_addr = '0;
  bit prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;
  logic prev_last = 1'b0;

  function automatic logic [WIDTH-1:0] word_of(input logic [TOTAL_BITS-1:0] g);
    return {~g, g};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: i_ready = 1'b1;
      1: i_ready = 1'($urandom % 2);
      default: i_ready = 1'b0;
    endcase
  end

  // Lane RAM model: lane L at local address a holds the word of global address {a, L}.
  logic [WIDTH-1:0] ram_pipe [RAM_LAT][NLANES];
  always @(posedge clk) begin
    for (int l = 0; l < NLANES; l++) begin
      for (int s = RAM_LAT-1; s > 0; s--) ram_pipe[s][l] <= ram_pipe[s-1][l];
      ram_pipe[0][l] <= o_ram_rd[l] ? word_of({o_ram_addr[l*LB +: LB], SWIZ_BITS'(l)}) : $urandom;
    end
  end
  always_comb begin
    i_ram_data = '0;
    for (int l = 0; l < NLANES; l++) i_ram_data[l*WIDTH +: WIDTH] = ram_pipe[RAM_LAT-1][l];
  end

  // Monitor: reads must walk the global addresses in order within credit; outputs match the scoreboard.
  always @(negedge clk) begin
    int outstanding;
    logic [TOTAL_BITS-1:0] g, ea;
    bit el;
    if (mon_en) begin
      outstanding = issued_tot - popped_tot;
      if (o_ram_rd != '0) begin
        check("rd_onehot", 64'($countones(o_ram_rd)), 1);
        check("rd_credit", 64'(outstanding < FIFO_DEPTH), 1);
      end
      for (int l = 0; l < NLANES; l++) begin
        if (o_ram_rd[l]) begin
          g = {o_ram_addr[l*LB +: LB], SWIZ_BITS'(l)};
          ea = (rd_exp_q.size() != 0) ? rd_exp_q.pop_front() : ~g;
          check("rd_addr", g, ea);
          issued_tot++;
          blk_issued++;
        end
      end
      if (prev_stall) begin
        check("stall_valid", o_valid, 1);
        check("stall_data", o_data, prev_data);
        check("stall_last", o_last, prev_last);
      end
      if (o_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (o_valid && i_ready) begin
        if (exp_q.size() != 0) begin
          ea = exp_q.pop_front();
          el = exp_last_q.pop_front();
          check("out_data", o_data, word_of(ea));
          check("out_last", o_last, el);
          last_pop_addr = ea;
        end else begin
          check("out_unexpected", o_valid, 0);
        end
        popped_tot++;
        blk_words++;
      end
      prev_stall = o_valid && !i_ready;
      prev_data  = o_data;
      prev_last  = o_last;
    end
  end

  task automatic send_req(input logic [TOTAL_BITS-1:0] a, input logic [LEN_BITS-1:0] n);
    int guard = 0;
    @(negedge clk);
    while (!o_req_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("req_ready_wait", o_req_ready, 1);
    i_req_valid = 1'b1;
    i_req_addr  = a;
    i_req_len   = n;
    for (int k = 0; k < int'(n); k++) begin
      exp_q.push_back(a + TOTAL_BITS'(k));
      exp_last_q.push_back(k == int'(n) - 1);
      rd_exp_q.push_back(a + TOTAL_BITS'(k));
    end
    blk_words = 0;
    blk_issued = 0;
    first_vld_cyc = -1;
    last_pop_addr = '0;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    i_req_valid = 1'b0;
    i_req_addr  = TOTAL_BITS'($urandom);
    i_req_len   = LEN_BITS'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || !o_req_ready) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", 64'(exp_q.size()), 0);
    check("drain_ready", o_req_ready, 1);
  endtask

  typedef struct {
    logic [TOTAL_BITS-1:0] addr;
    logic [LEN_BITS-1:0]   len;
    int                    exp_words;
    int                    exp_lat;
    logic [TOTAL_BITS-1:0] exp_last_addr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat, guard;
    vecs[0] = '{16'h0005, 8'd6,  6,  3, 16'h000A};
    vecs[1] = '{16'hFFFE, 8'd4,  4,  3, 16'h0001};
    vecs[2] = '{16'h0000, 8'd0,  0, -1, 16'h0000};
    vecs[3] = '{16'h0003, 8'd1,  1,  3, 16'h0003};
    vecs[4] = '{16'h1234, 8'd17, 17, 3, 16'h1244};
    vecs[5] = '{16'h7FFF, 8'd2,  2,  3, 16'h8000};

    reset = 1'b0; i_req_valid = 1'b0; i_req_addr = '0; i_req_len = '0; i_ready = 1'b0;
    #1;
    check("rst_valid", o_valid, 0);
    check("rst_rd", o_ram_rd, 0);
    check("rst_last", o_last, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_ready_after_release", o_req_ready, 1);
    mon_en = 1'b1;

    ready_mode = 0;
    for (int i = 0; i < 6; i++) begin
      send_req(vecs[i].addr, vecs[i].len);
      wait_done(400);
      repeat (4) @(negedge clk);
      lat = (first_vld_cyc < 0) ? -1 : first_vld_cyc - acc_cyc;
      check("vec_words", 64'(blk_words), 64'(vecs[i].exp_words));
      check("vec_latency", 64'(lat), 64'(vecs[i].exp_lat));
      check("vec_last_addr", last_pop_addr, vecs[i].exp_last_addr);
      check("vec_idle_ready", o_req_ready, 1);
    end

    // Backpressure: nothing accepted for 30 cycles, issue must stop at FIFO depth.
    ready_mode = 2;
    send_req(16'h0000, 8'd20);
    repeat (30) @(negedge clk);
    check("bp_issued", 64'(blk_issued), 64'(FIFO_DEPTH));
    check("bp_valid", o_valid, 1);
    ready_mode = 0;
    wait_done(400);
    check("bp_words", 64'(blk_words), 20);

    // Random requests with random backpressure, then a full-length block.
    for (int i = 0; i < 25; i++) begin
      ready_mode = int'($urandom_range(0, 1));
      send_req(TOTAL_BITS'($urandom), LEN_BITS'($urandom_range(0, 48)));
      wait_done(1000);
    end
    ready_mode = 1;
    send_req(TOTAL_BITS'($urandom), 8'd255);
    wait_done(3000);
    check("long_words", 64'(blk_words), 255);

    // Reset in the middle of a block.
    ready_mode = 0;
    send_req(16'h0040, 8'd12);
    guard = 0;
    while (blk_words < 3 && guard < 100) begin
      @(negedge clk);
      #2;
      guard++;
    end
    check("mid_words_before_reset", 64'(blk_words), 3);
    reset = 1'b0;
    mon_en = 1'b0;
    #1;
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_rd", o_ram_rd, 0);
    check("mid_rst_last", o_last, 0);
    check("mid_rst_data", o_data, 0);
    check("mid_rst_ready", o_req_ready, 0);
    exp_q.delete(); exp_last_q.delete(); rd_exp_q.delete();
    issued_tot = 0; popped_tot = 0; prev_stall = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    send_req(16'h0008, 8'd2);
    wait_done(400);
    repeat (6) @(negedge clk);
    check("post_rst_words", 64'(blk_words), 2);
    check("post_rst_last_addr", last_pop_addr, 16'h0009);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
